// File: rtl/longp_wbck_arb_pkg.sv
// -----------------------------------------------------------------------------
// longp_wbck_arb_pkg
// Shared definitions for the long-pipe writeback arbiter.
//   - MYRISCV_REGADDRWD : register-file index width
//   - LWBCK_NREQ        : default number of long-pipe completion sources
//   - LWBCK_STARVE_MAX  : default ALU anti-starvation threshold
//   - wb_src_e          : which source owns the write port this cycle
//   - ptr_width()       : width of a round-robin pointer (1 bit minimum)
// -----------------------------------------------------------------------------
package longp_wbck_arb_pkg;

    localparam int MYRISCV_REGADDRWD = 5;
    localparam int LWBCK_NREQ        = 2;
    localparam int LWBCK_STARVE_MAX  = 4;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_LP   = 2'd2
    } wb_src_e;

    // A single requester still needs a 1-bit pointer so the vector is legal;
    // that bit is tied to 0 by the arbiter.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/longp_wbck_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter for the long-pipe completion sources. Owns rr_ptr, the
// index of the highest-priority requester. The first requester found while
// scanning rr_ptr, rr_ptr+1, ... (mod N) receives the one-hot grant.
// Ports:
//   clk     : core clock
//   rst     : synchronous active-low reset (rr_ptr -> 0)
//   req     : request vector, one bit per requester
//   advance : the current grant was actually taken; move rr_ptr past winner
//   gnt     : one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter
    import longp_wbck_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = ptr_width(N);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] win_pos;
    logic [PW-1:0] scan_pos;
    logic          found;

    always_comb begin
        gnt      = '0;
        win_pos  = '0;
        scan_pos = '0;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            scan_pos = PW'((int'(rr_ptr) + k) % N);
            if (!found && req[scan_pos]) begin
                gnt[scan_pos] = 1'b1;
                win_pos       = scan_pos;
                found         = 1'b1;
            end
        end
    end

    generate
        if (N == 1) begin : g_single
            assign rr_ptr = '0;
        end else begin : g_multi
            // The pointer only moves when the long-pipe grant is consumed;
            // ALU grants and idle cycles leave it untouched.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rr_ptr <= '0;
                end else if (advance) begin
                    rr_ptr <= (win_pos == PW'(N - 1)) ? '0 : win_pos + PW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/longp_wbck_arb.sv
// -----------------------------------------------------------------------------
// longp_wbck_arb
// Writeback arbiter for the single register-file write port. Long-pipe
// completions (round-robin among themselves) beat the single-cycle ALU
// writeback, except when the ALU has been blocked STARVE_MAX consecutive
// cycles, in which case the ALU is forced through. Every long-pipe grant also
// produces a registered OITF retire pulse (clr_req/clr_idx).
// Ports:
//   clk, rst              : core clock, synchronous active-low reset
//   alu_wb_vld/idx/data   : ALU writeback request
//   alu_wb_rdy            : ALU request accepted this cycle (combinational)
//   lp_vld/idx/data       : packed long-pipe requests, requester i at slice i
//   lp_rdy                : one-hot long-pipe accept (combinational)
//   rf_wen/widx/wdata     : registered register-file write
//   clr_req/clr_idx       : registered OITF retire pulse and index
// -----------------------------------------------------------------------------
module longp_wbck_arb
    import longp_wbck_arb_pkg::*;
#(
    parameter int NREQ       = LWBCK_NREQ,
    parameter int DW         = 32,
    parameter int AW         = MYRISCV_REGADDRWD,
    parameter int STARVE_MAX = LWBCK_STARVE_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_wb_vld,
    input  logic [AW-1:0]      alu_wb_idx,
    input  logic [DW-1:0]      alu_wb_data,
    output logic               alu_wb_rdy,
    input  logic [NREQ-1:0]    lp_vld,
    input  logic [NREQ*AW-1:0] lp_idx,
    input  logic [NREQ*DW-1:0] lp_data,
    output logic [NREQ-1:0]    lp_rdy,
    output logic               rf_wen,
    output logic [AW-1:0]      rf_widx,
    output logic [DW-1:0]      rf_wdata,
    output logic               clr_req,
    output logic [AW-1:0]      clr_idx
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0]   starve_cnt;
    logic [NREQ-1:0] arb_gnt;
    logic            lp_any;
    logic            alu_force;
    logic            lp_win;
    logic            alu_win;
    wb_src_e         src;
    logic [AW-1:0]   lp_sel_idx;
    logic [DW-1:0]   lp_sel_data;
    logic [AW-1:0]   gnt_idx;
    logic [DW-1:0]   gnt_data;
    logic            wen_nxt;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (lp_vld),
        .advance (lp_win),
        .gnt     (arb_gnt)
    );

    // Grant decision. Both accepts are gated by rst so nothing is consumed
    // while reset is held. The override also requires alu_wb_vld so a
    // withdrawn ALU request never leaves the port idle with long-pipe work.
    assign lp_any    = |lp_vld;
    assign alu_force = alu_wb_vld && (starve_cnt == SW'(STARVE_MAX));
    assign lp_win    = rst && lp_any && !alu_force;
    assign alu_win   = rst && alu_wb_vld && !lp_win;

    assign alu_wb_rdy = alu_win;
    assign lp_rdy     = lp_win ? arb_gnt : '0;

    // One-hot mux of the winning long-pipe slice.
    always_comb begin
        lp_sel_idx  = '0;
        lp_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                lp_sel_idx  = lp_idx[i*AW +: AW];
                lp_sel_data = lp_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        if (lp_win) begin
            src = WB_SRC_LP;
        end else if (alu_win) begin
            src = WB_SRC_ALU;
        end else begin
            src = WB_SRC_NONE;
        end
    end

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        case (src)
            WB_SRC_LP: begin
                gnt_idx  = lp_sel_idx;
                gnt_data = lp_sel_data;
            end
            WB_SRC_ALU: begin
                gnt_idx  = alu_wb_idx;
                gnt_data = alu_wb_data;
            end
            default: begin
                gnt_idx  = '0;
                gnt_data = '0;
            end
        endcase
    end

    // Writes to x0 are dropped at the register file but still retire in the
    // OITF, so wen and clr_req are qualified differently.
    assign wen_nxt = (src != WB_SRC_NONE) && (gnt_idx != '0);

    // Consecutive cycles the ALU has waited; saturates at STARVE_MAX.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!alu_wb_vld || alu_win) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Registered write port and retire pulse, one cycle after the grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_wen   <= 1'b0;
            rf_widx  <= '0;
            rf_wdata <= '0;
            clr_req  <= 1'b0;
            clr_idx  <= '0;
        end else begin
            rf_wen  <= wen_nxt;
            clr_req <= lp_win;
            if (wen_nxt) begin
                rf_widx  <= gnt_idx;
                rf_wdata <= gnt_data;
            end
            if (lp_win) begin
                clr_idx <= lp_sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_longp_wbck_arb.sv
// -----------------------------------------------------------------------------
// tb_longp_wbck_arb
// Vector table of {inputs, expected accepts}; the expected registered write
// and retire pulse for each vector are queued when it is driven and compared
// one clock later when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_longp_wbck_arb;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int SMAX = 4;

    logic               clk;
    logic               rst;
    logic               alu_wb_vld;
    logic [AW-1:0]      alu_wb_idx;
    logic [DW-1:0]      alu_wb_data;
    logic               alu_wb_rdy;
    logic [NREQ-1:0]    lp_vld;
    logic [NREQ*AW-1:0] lp_idx;
    logic [NREQ*DW-1:0] lp_data;
    logic [NREQ-1:0]    lp_rdy;
    logic               rf_wen;
    logic [AW-1:0]      rf_widx;
    logic [DW-1:0]      rf_wdata;
    logic               clr_req;
    logic [AW-1:0]      clr_idx;

    longp_wbck_arb #(
        .NREQ       (NREQ),
        .DW         (DW),
        .AW         (AW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_wb_vld  (alu_wb_vld),
        .alu_wb_idx  (alu_wb_idx),
        .alu_wb_data (alu_wb_data),
        .alu_wb_rdy  (alu_wb_rdy),
        .lp_vld      (lp_vld),
        .lp_idx      (lp_idx),
        .lp_data     (lp_data),
        .lp_rdy      (lp_rdy),
        .rf_wen      (rf_wen),
        .rf_widx     (rf_widx),
        .rf_wdata    (rf_wdata),
        .clr_req     (clr_req),
        .clr_idx     (clr_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        alu_vld;
        logic [4:0]  alu_idx;
        logic [31:0] alu_data;
        logic [1:0]  lv;
        logic [4:0]  i0;
        logic [4:0]  i1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        exp_alu;
        logic [1:0]  exp_lp;
    } vec_t;

    typedef struct {
        logic        wen;
        logic [4:0]  widx;
        logic [31:0] wdata;
        logic        clr;
        logic [4:0]  cidx;
        logic        all;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ai,
                                input logic [31:0] ad, input logic [1:0] lv,
                                input logic [4:0] i0, input logic [4:0] i1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic ea, input logic [1:0] el);
        vec_t v;
        v.rst_n = r;  v.alu_vld = av; v.alu_idx = ai; v.alu_data = ad;
        v.lv = lv;    v.i0 = i0;      v.i1 = i1;      v.d0 = d0; v.d1 = d1;
        v.exp_alu = ea; v.exp_lp = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one vector, check the accepts mid-cycle, queue the expected
    // registered result, then compare it just after the clock edge.
    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t g;
        rst         = v.rst_n;
        alu_wb_vld  = v.alu_vld;
        alu_wb_idx  = v.alu_idx;
        alu_wb_data = v.alu_data;
        lp_vld      = v.lv;
        lp_idx      = {v.i1, v.i0};
        lp_data     = {v.d1, v.d0};
        #3;
        chk("alu_wb_rdy", 64'(alu_wb_rdy), 64'(v.exp_alu));
        chk("lp_rdy", 64'(lp_rdy), 64'(v.exp_lp));
        e = '{wen: 1'b0, widx: 5'd0, wdata: 32'd0, clr: 1'b0, cidx: 5'd0, all: 1'b0};
        if (!v.rst_n) begin
            e.all = 1'b1;
        end else if (v.exp_alu) begin
            e.wen = (v.alu_idx != 5'd0); e.widx = v.alu_idx; e.wdata = v.alu_data;
        end else if (v.exp_lp[0]) begin
            e.wen = (v.i0 != 5'd0); e.widx = v.i0; e.wdata = v.d0;
            e.clr = 1'b1; e.cidx = v.i0;
        end else if (v.exp_lp[1]) begin
            e.wen = (v.i1 != 5'd0); e.widx = v.i1; e.wdata = v.d1;
            e.clr = 1'b1; e.cidx = v.i1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: got empty queue, expected one entry");
        end else begin
            g = exp_q.pop_front();
            chk("rf_wen", 64'(rf_wen), 64'(g.wen));
            chk("clr_req", 64'(clr_req), 64'(g.clr));
            if (g.wen || g.all) begin
                chk("rf_widx", 64'(rf_widx), 64'(g.widx));
                chk("rf_wdata", 64'(rf_wdata), 64'(g.wdata));
            end
            if (g.clr || g.all) begin
                chk("clr_idx", 64'(clr_idx), 64'(g.cidx));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; alu_wb_vld = 1'b0; alu_wb_idx = '0; alu_wb_data = '0;
        lp_vld = '0; lp_idx = '0; lp_data = '0;

        // reset held 3 cycles with everything valid: nothing accepted
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1, 5'd1, 32'h1, 2'b11, 5'd2, 5'd3, 32'h2, 32'h3, 0, 2'b00));
        // single long write, then lp1 alone to bring rr_ptr back to 0
        tbl.push_back(mk(1, 0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd8, 32'h0, 32'h8888, 0, 2'b10));
        // round-robin from rr_ptr=0: 0,1,0,1
        tbl.push_back(mk(1, 0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd4, 32'hA0A0, 32'hB1B1, 0, 2'b01));
        tbl.push_back(mk(1, 0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd4, 32'hA0A0, 32'hB1B1, 0, 2'b10));
        tbl.push_back(mk(1, 0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd4, 32'hA0A0, 32'hB1B1, 0, 2'b01));
        tbl.push_back(mk(1, 0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd4, 32'hA0A0, 32'hB1B1, 0, 2'b10));
        // idle, ALU alone, lp1 to x0, ALU to x0
        tbl.push_back(mk(1, 0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 2'b00));
        tbl.push_back(mk(1, 1, 5'd12, 32'h1234, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1, 2'b00));
        tbl.push_back(mk(1, 0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd0, 32'h0, 32'h0BAD, 0, 2'b10));
        tbl.push_back(mk(1, 1, 5'd0, 32'h77, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1, 2'b00));
        // starvation: lp0 wins 4 times, ALU forced on the 5th, then lp0
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 5'd20, 32'h55, 2'b01, 5'd6, 5'd0, 32'h66, 32'h0, 0, 2'b01));
        tbl.push_back(mk(1, 1, 5'd20, 32'h55, 2'b01, 5'd6, 5'd0, 32'h66, 32'h0, 1, 2'b00));
        tbl.push_back(mk(1, 1, 5'd20, 32'h55, 2'b01, 5'd6, 5'd0, 32'h66, 32'h0, 0, 2'b01));
        // everyone valid (rr_ptr=1, starve_cnt=1): 1,0,1, ALU, then 0 (ptr held)
        tbl.push_back(mk(1, 1, 5'd21, 32'h99, 2'b11, 5'd6, 5'd7, 32'h66, 32'h77, 0, 2'b10));
        tbl.push_back(mk(1, 1, 5'd21, 32'h99, 2'b11, 5'd6, 5'd7, 32'h66, 32'h77, 0, 2'b01));
        tbl.push_back(mk(1, 1, 5'd21, 32'h99, 2'b11, 5'd6, 5'd7, 32'h66, 32'h77, 0, 2'b10));
        tbl.push_back(mk(1, 1, 5'd21, 32'h99, 2'b11, 5'd6, 5'd7, 32'h66, 32'h77, 1, 2'b00));
        tbl.push_back(mk(1, 1, 5'd21, 32'h99, 2'b11, 5'd6, 5'd7, 32'h66, 32'h77, 0, 2'b01));
        tbl.push_back(mk(1, 0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 2'b00));

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset mid-stream: rr_ptr=1 and starve_cnt=2 before reset; the last
        // pre-reset write is still visible, then everything clears.
        run_vec(mk(1, 1, 5'd25, 32'hAA, 2'b01, 5'd11, 5'd13, 32'hCAFE, 32'hD00D, 0, 2'b01));
        run_vec(mk(1, 1, 5'd25, 32'hAA, 2'b01, 5'd11, 5'd13, 32'hCAFE, 32'hD00D, 0, 2'b01));
        run_vec(mk(0, 1, 5'd25, 32'hAA, 2'b11, 5'd11, 5'd13, 32'hCAFE, 32'hD00D, 0, 2'b00));
        // After release rr_ptr=0 (lp0 first) and starve_cnt=0 (ALU on 5th).
        run_vec(mk(1, 1, 5'd25, 32'hAA, 2'b11, 5'd11, 5'd13, 32'hCAFE, 32'hD00D, 0, 2'b01));
        run_vec(mk(1, 1, 5'd25, 32'hAA, 2'b11, 5'd11, 5'd13, 32'hCAFE, 32'hD00D, 0, 2'b10));
        run_vec(mk(1, 1, 5'd25, 32'hAA, 2'b11, 5'd11, 5'd13, 32'hCAFE, 32'hD00D, 0, 2'b01));
        run_vec(mk(1, 1, 5'd25, 32'hAA, 2'b11, 5'd11, 5'd13, 32'hCAFE, 32'hD00D, 0, 2'b10));
        run_vec(mk(1, 1, 5'd25, 32'hAA, 2'b11, 5'd11, 5'd13, 32'hCAFE, 32'hD00D, 1, 2'b00));
        run_vec(mk(1, 0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 2'b00));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
